zap_mem_access_ctrl: RTL and testbench

Sequences each data-memory access issued by the ALU stage onto the data-cache bus and drives the data-stall and fault inputs of the memory stage. It performs the following functions:
- generates byte lanes and replicated store data;
- holds the pipeline until the cache acks or errs;
- enforces an optional alignment check and a bus timeout;
- safely retires a bus cycle that is orphaned by a writeback flush.
It sits between the ALU-stage output flops and the memory stage, and is the sole master of the data-cache port.

---
 rtl/zap_mem_access_ctrl_pkg.sv | 45 ++++
 rtl/zap_mem_access_ctrl_if.sv | 24 ++
 rtl/zap_mem_lane_gen.sv | 21 ++
 rtl/zap_mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_zap_mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/zap_mem_access_ctrl_pkg.sv
// rtl/zap_mem_access_ctrl_pkg.sv - shared FSM encodings, access size and lane helpers
package zap_mem_access_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic size_e get_size(input logic sb, input logic ub,
                                       input logic sh, input logic uh);
        if (sb | ub)
            return SZ_BYTE;
        else if (sh | uh)
            return SZ_HALF;
        else
            return SZ_WORD;
    endfunction

    function automatic logic [3:0] lane_sel(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_data(input size_e sz, input logic [31:0] v);
        case (sz)
            SZ_BYTE: return {4{v[7:0]}};
            SZ_HALF: return {2{v[15:0]}};
            default: return v;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] a);
        return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/zap_mem_access_ctrl_if.sv
// rtl/zap_mem_access_ctrl_if.sv - data-cache bus bundle between controller and cache
interface zap_mem_access_ctrl_if;
    logic        o_data_wb_cyc;
    logic        o_data_wb_stb;
    logic        o_data_wb_we;
    logic [3:0]  o_data_wb_sel;
    logic [31:0] o_data_wb_adr;
    logic [31:0] o_data_wb_dat;
    logic        i_data_wb_ack;
    logic        i_data_wb_err;
    logic [31:0] i_data_wb_dat;

    modport master (
        output o_data_wb_cyc, o_data_wb_stb, o_data_wb_we, o_data_wb_sel,
               o_data_wb_adr, o_data_wb_dat,
        input  i_data_wb_ack, i_data_wb_err, i_data_wb_dat
    );

    modport slave (
        input  o_data_wb_cyc, o_data_wb_stb, o_data_wb_we, o_data_wb_sel,
               o_data_wb_adr, o_data_wb_dat,
        output i_data_wb_ack, i_data_wb_err, i_data_wb_dat
    );
endinterface

// File: rtl/zap_mem_lane_gen.sv
// rtl/zap_mem_lane_gen.sv - size/address to byte lanes, replicated store data, misalign flag
module zap_mem_lane_gen
    import zap_mem_access_ctrl_pkg::*;
(
    input  logic        i_sbyte,
    input  logic        i_ubyte,
    input  logic        i_shalf,
    input  logic        i_uhalf,
    input  logic [1:0]  i_adr_lo,
    input  logic [31:0] i_value,
    output logic [3:0]  o_sel,
    output logic [31:0] o_dat,
    output logic        o_misaligned
);
    size_e w_size;

    assign w_size       = get_size(i_sbyte, i_ubyte, i_shalf, i_uhalf);
    assign o_sel        = lane_sel(w_size, i_adr_lo);
    assign o_dat        = rep_data(w_size, i_value);
    assign o_misaligned = misaligned(w_size, i_adr_lo);
endmodule

// File: rtl/zap_mem_access_ctrl.sv
// rtl/zap_mem_access_ctrl.sv - sequences ALU-stage memory accesses onto the data-cache bus
module zap_mem_access_ctrl
    import zap_mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT     = 256,
    parameter bit ALIGN_CHECK = 1'b0,
    parameter int CNT_WDT     = 9
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear_from_writeback,
    input  logic                    i_mem_load_ff,
    input  logic                    i_mem_store_ff,
    input  logic [31:0]             i_mem_address_ff,
    input  logic [31:0]             i_mem_srcdest_value_ff,
    input  logic                    i_sbyte_ff,
    input  logic                    i_ubyte_ff,
    input  logic                    i_shalf_ff,
    input  logic                    i_uhalf_ff,
    zap_mem_access_ctrl_if.master   io_dbus,
    output logic                    o_data_stall,
    output logic [31:0]             o_mem_rd_data,
    output logic                    o_mem_fault
);
    localparam logic [CNT_WDT-1:0] TMO_LAST = CNT_WDT'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [CNT_WDT-1:0] r_cnt;
    logic               r_cyc;
    logic               r_stb;
    logic               r_we;
    logic [3:0]         r_sel;
    logic [31:0]        r_adr;
    logic [31:0]        r_dat;
    logic [31:0]        r_rd_data;
    logic               r_fault;

    logic               w_req;
    logic               w_tmo;
    logic [CNT_WDT-1:0] w_cnt_inc;
    logic [3:0]         w_sel;
    logic [31:0]        w_dat;
    logic               w_misaligned;

    zap_mem_lane_gen u_lane_gen (
        .i_sbyte      (i_sbyte_ff),
        .i_ubyte      (i_ubyte_ff),
        .i_shalf      (i_shalf_ff),
        .i_uhalf      (i_uhalf_ff),
        .i_adr_lo     (i_mem_address_ff[1:0]),
        .i_value      (i_mem_srcdest_value_ff),
        .o_sel        (w_sel),
        .o_dat        (w_dat),
        .o_misaligned (w_misaligned)
    );

    assign w_req     = (i_mem_load_ff | i_mem_store_ff) & ~i_clear_from_writeback;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_WDT'(1);
    // Fires on the TIMEOUT-th cycle spent waiting on the bus.
    assign w_tmo     = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

    always_comb begin
        o_data_stall = 1'b1;
        case (r_state)
            S_IDLE:  o_data_stall = w_req;
            S_DONE:  o_data_stall = 1'b0;
            default: o_data_stall = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'b0000;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_rd_data <= 32'h0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_fault <= 1'b0;
                    if (w_req) begin
                        if (ALIGN_CHECK && w_misaligned) begin
                            r_state <= S_DONE;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= '0;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= i_mem_store_ff;
                            r_sel   <= w_sel;
                            r_adr   <= {i_mem_address_ff[31:2], 2'b00};
                            r_dat   <= w_dat;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (io_dbus.i_data_wb_err || w_tmo) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_DONE;
                    end else if (io_dbus.i_data_wb_ack) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_fault <= 1'b0;
                        if (!r_we)
                            r_rd_data <= io_dbus.i_data_wb_dat;
                        r_state <= S_DONE;
                    end else if (i_clear_from_writeback) begin
                        r_state <= S_DRAIN;
                    end
                end
                // The flushed transfer must still complete on the bus; its result is dropped.
                S_DRAIN: begin
                    r_cnt <= w_cnt_inc;
                    if (io_dbus.i_data_wb_ack || io_dbus.i_data_wb_err || w_tmo) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_fault <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_fault <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_dbus.o_data_wb_cyc = r_cyc;
    assign io_dbus.o_data_wb_stb = r_stb;
    assign io_dbus.o_data_wb_we  = r_we;
    assign io_dbus.o_data_wb_sel = r_sel;
    assign io_dbus.o_data_wb_adr = r_adr;
    assign io_dbus.o_data_wb_dat = r_dat;
    assign o_mem_rd_data         = r_rd_data;
    assign o_mem_fault           = r_fault;
endmodule

// File: tb/tb_zap_mem_access_ctrl.sv
// tb/tb_zap_mem_access_ctrl.sv - directed self-checking bench for zap_mem_access_ctrl
module tb_zap_mem_access_ctrl;

    logic        clk;
    logic        rst_a, rst_b;
    logic        clr, ld, st;
    logic [31:0] addr, val;
    logic        sb, ub, sh, uh;
    logic        stall_a, stall_b, fault_a, fault_b;
    logic [31:0] rd_a, rd_b;

    int n_checks = 0;
    int n_errors = 0;

    zap_mem_access_ctrl_if bus_a ();
    zap_mem_access_ctrl_if bus_b ();

    zap_mem_access_ctrl #(.TIMEOUT(8), .ALIGN_CHECK(1'b0), .CNT_WDT(9)) dut_a (
        .i_clk (clk), .i_reset (rst_a), .i_clear_from_writeback (clr),
        .i_mem_load_ff (ld), .i_mem_store_ff (st),
        .i_mem_address_ff (addr), .i_mem_srcdest_value_ff (val),
        .i_sbyte_ff (sb), .i_ubyte_ff (ub), .i_shalf_ff (sh), .i_uhalf_ff (uh),
        .io_dbus (bus_a.master),
        .o_data_stall (stall_a), .o_mem_rd_data (rd_a), .o_mem_fault (fault_a)
    );

    zap_mem_access_ctrl #(.TIMEOUT(0), .ALIGN_CHECK(1'b1), .CNT_WDT(9)) dut_b (
        .i_clk (clk), .i_reset (rst_b), .i_clear_from_writeback (clr),
        .i_mem_load_ff (ld), .i_mem_store_ff (st),
        .i_mem_address_ff (addr), .i_mem_srcdest_value_ff (val),
        .i_sbyte_ff (sb), .i_ubyte_ff (ub), .i_shalf_ff (sh), .i_uhalf_ff (uh),
        .io_dbus (bus_b.master),
        .o_data_stall (stall_b), .o_mem_rd_data (rd_b), .o_mem_fault (fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // sz: 0 = byte, 1 = half, 2 = word
    task automatic set_req(input logic l, input logic s, input logic [31:0] a,
                           input logic [31:0] v, input int sz);
        ld = l; st = s; addr = a; val = v;
        sb = 1'b0; sh = 1'b0;
        ub = (sz == 0);
        uh = (sz == 1);
    endtask

    task automatic drop_req();
        ld = 1'b0; st = 1'b0;
    endtask

    // Full access on DUT A, entered at a negedge with the FSM in IDLE.
    task automatic access_a(input string tag, input logic l, input logic s,
                            input logic [31:0] a, input logic [31:0] v, input int sz,
                            input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                            input int waits, input logic ackv, input logic errv,
                            input logic [31:0] rdata, input logic [31:0] exp_rd,
                            input logic exp_fault);
        set_req(l, s, a, v, sz);
        #1;
        check({tag, "_idle_stall"}, 32'(stall_a), 32'd1);
        @(negedge clk);
        check({tag, "_cyc"}, 32'(bus_a.o_data_wb_cyc), 32'd1);
        check({tag, "_stb"}, 32'(bus_a.o_data_wb_stb), 32'd1);
        check({tag, "_we"}, 32'(bus_a.o_data_wb_we), 32'(s));
        check({tag, "_sel"}, 32'(bus_a.o_data_wb_sel), 32'(exp_sel));
        check({tag, "_adr"}, bus_a.o_data_wb_adr, {a[31:2], 2'b00});
        check({tag, "_dat"}, bus_a.o_data_wb_dat, exp_dat);
        check({tag, "_busy_stall"}, 32'(stall_a), 32'd1);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check({tag, "_wait_cyc"}, 32'(bus_a.o_data_wb_cyc), 32'd1);
        end
        bus_a.i_data_wb_ack = ackv;
        bus_a.i_data_wb_err = errv;
        bus_a.i_data_wb_dat = rdata;
        @(negedge clk);
        bus_a.i_data_wb_ack = 1'b0;
        bus_a.i_data_wb_err = 1'b0;
        check({tag, "_done_stall"}, 32'(stall_a), 32'd0);
        check({tag, "_done_cyc"}, 32'(bus_a.o_data_wb_cyc), 32'd0);
        check({tag, "_done_fault"}, 32'(fault_a), 32'(exp_fault));
        check({tag, "_done_rd"}, rd_a, exp_rd);
        drop_req();
        @(negedge clk);
        check({tag, "_idle_fault"}, 32'(fault_a), 32'd0);
    endtask

    initial begin
        int  n;
        logic ok;
        rst_a = 1'b1; rst_b = 1'b1; clr = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 2);
        bus_a.i_data_wb_ack = 1'b0; bus_a.i_data_wb_err = 1'b0; bus_a.i_data_wb_dat = 32'h0;
        bus_b.i_data_wb_ack = 1'b0; bus_b.i_data_wb_err = 1'b0; bus_b.i_data_wb_dat = 32'h0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);

        check("rst_cyc", 32'(bus_a.o_data_wb_cyc), 32'd0);
        check("rst_stb", 32'(bus_a.o_data_wb_stb), 32'd0);
        check("rst_we", 32'(bus_a.o_data_wb_we), 32'd0);
        check("rst_sel", 32'(bus_a.o_data_wb_sel), 32'd0);
        check("rst_adr", bus_a.o_data_wb_adr, 32'h0);
        check("rst_dat", bus_a.o_data_wb_dat, 32'h0);
        check("rst_rd", rd_a, 32'h0);
        check("rst_fault", 32'(fault_a), 32'd0);
        check("rst_stall", 32'(stall_a), 32'd0);

        access_a("wload", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 2, 4'b1111, 32'h0,
                 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        access_a("bstore", 1'b0, 1'b1, 32'h0000_1003, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5,
                 0, 1'b1, 1'b0, 32'h5555_5555, 32'hDEAD_BEEF, 1'b0);
        access_a("hstore", 1'b0, 1'b1, 32'h0000_1002, 32'h0000_1234, 1, 4'b1100, 32'h1234_1234,
                 1, 1'b1, 1'b0, 32'h5555_5555, 32'hDEAD_BEEF, 1'b0);
        access_a("errack", 1'b1, 1'b0, 32'h0000_1004, 32'h0, 2, 4'b1111, 32'h0,
                 4, 1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);

        // Timeout after 8 BUSY cycles
        set_req(1'b1, 1'b0, 32'h0000_2000, 32'h0, 2);
        @(negedge clk);
        n = 0;
        while (bus_a.o_data_wb_cyc && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("tmo_cycles", 32'(n), 32'd8);
        check("tmo_stall", 32'(stall_a), 32'd0);
        check("tmo_fault", 32'(fault_a), 32'd1);
        drop_req();
        @(negedge clk);
        check("tmo_idle_fault", 32'(fault_a), 32'd0);

        // Flush in 2nd BUSY cycle, ack 3 cycles later
        set_req(1'b1, 1'b0, 32'h0000_4000, 32'h0, 2);
        @(negedge clk);
        check("drain_busy1_cyc", 32'(bus_a.o_data_wb_cyc), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        drop_req();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drain_cyc", 32'(bus_a.o_data_wb_cyc), 32'd1);
            check("drain_stall", 32'(stall_a), 32'd1);
            if (i < 2) @(negedge clk);
        end
        bus_a.i_data_wb_ack = 1'b1;
        bus_a.i_data_wb_dat = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_a.i_data_wb_ack = 1'b0;
        check("drain_end_cyc", 32'(bus_a.o_data_wb_cyc), 32'd0);
        check("drain_end_stall", 32'(stall_a), 32'd0);
        check("drain_end_fault", 32'(fault_a), 32'd0);
        check("drain_end_rd", rd_a, 32'hDEAD_BEEF);
        @(negedge clk);
        check("drain_idle_fault", 32'(fault_a), 32'd0);
        check("drain_idle_cyc", 32'(bus_a.o_data_wb_cyc), 32'd0);

        access_a("misal_noalign", 1'b1, 1'b0, 32'h0000_1002, 32'h0, 2, 4'b1111, 32'h0,
                 0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

        // Second instance: ALIGN_CHECK = 1, TIMEOUT = 0
        rst_a = 1'b1;
        rst_b = 1'b0;
        @(negedge clk);
        check("b_rst_stall", 32'(stall_b), 32'd0);
        check("b_rst_cyc", 32'(bus_b.o_data_wb_cyc), 32'd0);

        set_req(1'b1, 1'b0, 32'h0000_1002, 32'h0, 2);
        #1;
        check("align_idle_stall", 32'(stall_b), 32'd1);
        check("align_idle_cyc", 32'(bus_b.o_data_wb_cyc), 32'd0);
        @(negedge clk);
        check("align_done_cyc", 32'(bus_b.o_data_wb_cyc), 32'd0);
        check("align_done_stall", 32'(stall_b), 32'd0);
        check("align_done_fault", 32'(fault_b), 32'd1);
        drop_req();
        @(negedge clk);
        check("align_idle_fault", 32'(fault_b), 32'd0);
        check("align_idle_cyc2", 32'(bus_b.o_data_wb_cyc), 32'd0);

        set_req(1'b1, 1'b0, 32'h0000_3000, 32'h0, 2);
        @(negedge clk);
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (!(stall_b && bus_b.o_data_wb_cyc && !fault_b)) ok = 1'b0;
            @(negedge clk);
        end
        check("notmo_hold", 32'(ok), 32'd1);
        bus_b.i_data_wb_ack = 1'b1;
        bus_b.i_data_wb_dat = 32'h0BAD_F00D;
        @(negedge clk);
        bus_b.i_data_wb_ack = 1'b0;
        check("notmo_done_stall", 32'(stall_b), 32'd0);
        check("notmo_done_fault", 32'(fault_b), 32'd0);
        check("notmo_done_rd", rd_b, 32'h0BAD_F00D);
        drop_req();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
